// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory boot loader: sizes, load states
// and the word-counter width helper.
package imem_pkg;

   localparam int IMEM_DEPTH_WORDS = 4096;
   localparam int IMEM_WORD_W      = 32;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEN   = 3'd1,
      ST_DATA  = 3'd2,
      ST_WRITE = 3'd3,
      ST_FIN   = 3'd4,
      ST_FAIL  = 3'd5
   } load_state_t;

   // word_count must be able to hold DEPTH_WORDS itself, not just DEPTH_WORDS-1.
   function automatic int wc_width(input int depth_words);
      return $clog2(depth_words + 1);
   endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian 4-byte assembler. o_word/o_complete are valid in the cycle the
// fourth byte is presented, so the caller can latch the whole word on that edge.
module byte_packer
   import imem_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_clear,
   input  logic                   i_valid,
   input  logic [7:0]             i_byte,
   output logic [IMEM_WORD_W-1:0] o_word,
   output logic                   o_complete
);

   logic [1:0]  r_idx;
   logic [23:0] r_buf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx <= '0;
         r_buf <= '0;
      end else if (i_clear) begin
         r_idx <= '0;
         r_buf <= '0;
      end else if (i_valid) begin
         case (r_idx)
            2'd0:    r_buf[7:0]   <= i_byte;
            2'd1:    r_buf[15:8]  <= i_byte;
            2'd2:    r_buf[23:16] <= i_byte;
            default: r_buf        <= r_buf;
         endcase
         r_idx <= r_idx + 2'd1;
      end
   end

   assign o_complete = i_valid && (r_idx == 2'd3);
   assign o_word     = {i_byte, r_buf};

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: takes a length-prefixed little-endian
// byte stream and writes 32-bit words at consecutive addresses, holding the core.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; done/err hold the last load's outcome
// ST_LEN   | collecting the 4-byte word count N
// ST_DATA  | collecting the 4 bytes of the next word
// ST_WRITE | wr_en high, address/data held until wr_ready
// ST_FIN   | load complete, done raised, core released
// ST_FAIL  | N exceeded memory depth, err raised, nothing written
module imem_loader
   import imem_pkg::*;
#(
   parameter int                ADDR_W      = 64,
   parameter int                DEPTH_WORDS = IMEM_DEPTH_WORDS,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
   localparam int               WC_W        = wc_width(DEPTH_WORDS)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   in_valid,
   input  logic [7:0]             in_data,
   output logic                   in_ready,
   output logic                   wr_en,
   output logic [ADDR_W-1:0]      wr_addr,
   output logic [IMEM_WORD_W-1:0] wr_data,
   input  logic                   wr_ready,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic [WC_W-1:0]        word_count,
   output logic                   cpu_hold
);

   localparam logic [31:0] DEPTH32 = 32'(DEPTH_WORDS);

   load_state_t r_state;
   load_state_t w_next;

   logic [31:0]            r_len;
   logic [WC_W-1:0]        r_word_count;
   logic [IMEM_WORD_W-1:0] r_wr_data;
   logic                   r_in_ready;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_err;
   logic                   r_cpu_hold;

   logic                   w_accept;
   logic                   w_start_ok;
   logic                   w_last_word;
   logic                   w_enter_fin;
   logic                   w_enter_fail;
   logic [IMEM_WORD_W-1:0] w_pack_word;
   logic                   w_pack_complete;

   assign w_accept     = in_valid && r_in_ready;
   assign w_start_ok   = (r_state == ST_IDLE) && start;
   assign w_last_word  = (32'(r_word_count) + 32'd1) == r_len;
   assign w_enter_fin  = (w_next == ST_FIN)  && (r_state != ST_FIN);
   assign w_enter_fail = (w_next == ST_FAIL) && (r_state != ST_FAIL);

   byte_packer u_packer (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clear    (w_start_ok),
      .i_valid    (w_accept),
      .i_byte     (in_data),
      .o_word     (w_pack_word),
      .o_complete (w_pack_complete)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (start) w_next = ST_LEN;
         end
         ST_LEN: begin
            // Full 32-bit compare so large counts cannot alias into range.
            if (w_pack_complete) begin
               if (w_pack_word == '0)          w_next = ST_FIN;
               else if (w_pack_word > DEPTH32) w_next = ST_FAIL;
               else                            w_next = ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_pack_complete) w_next = ST_WRITE;
         end
         ST_WRITE: begin
            if (wr_ready) w_next = w_last_word ? ST_FIN : ST_DATA;
         end
         ST_FIN:  w_next = ST_IDLE;
         ST_FAIL: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_in_ready   <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_cpu_hold   <= 1'b0;
         r_len        <= '0;
         r_word_count <= '0;
         r_wr_data    <= '0;
      end else begin
         r_in_ready <= (w_next == ST_LEN) || (w_next == ST_DATA);
         if (w_start_ok) begin
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_busy       <= 1'b1;
            r_cpu_hold   <= 1'b1;
            r_len        <= '0;
            r_word_count <= '0;
         end
         if ((r_state == ST_LEN) && w_pack_complete) begin
            r_len <= w_pack_word;
         end
         if ((r_state == ST_DATA) && w_pack_complete) begin
            r_wr_data <= w_pack_word;
         end
         if ((r_state == ST_WRITE) && wr_ready) begin
            r_word_count <= r_word_count + WC_W'(1);
         end
         if (w_enter_fin) begin
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_cpu_hold <= 1'b0;
         end
         if (w_enter_fail) begin
            r_err      <= 1'b1;
            r_busy     <= 1'b0;
            r_cpu_hold <= 1'b0;
         end
      end
   end

   always_comb begin
      in_ready   = r_in_ready;
      wr_en      = (r_state == ST_WRITE);
      wr_addr    = BASE_ADDR + (ADDR_W'(r_word_count) << 2);
      wr_data    = r_wr_data;
      busy       = r_busy;
      done       = r_done;
      err        = r_err;
      word_count = r_word_count;
      cpu_hold   = r_cpu_hold;
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed-vector bench for imem_loader: each task drives one scenario and
// checks outputs against hand-computed values.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        wr_en;
   logic [63:0] wr_addr;
   logic [31:0] wr_data;
   logic        wr_ready;
   logic        busy;
   logic        done;
   logic        err;
   logic [12:0] word_count;
   logic        cpu_hold;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [63:0] addr;
      logic [31:0] data;
   } wr_rec_t;

   wr_rec_t wq[$];
   wr_rec_t rec;
   int      wren_cycles = 0;
   int      cyc = 0;

   always #5 clk = ~clk;

   imem_loader #(
      .ADDR_W      (64),
      .DEPTH_WORDS (4096),
      .BASE_ADDR   (64'h0)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_ready   (wr_ready),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .word_count (word_count),
      .cpu_hold   (cpu_hold)
   );

   // memory-side monitor: captures every accepted write
   always @(posedge clk) begin
      cyc++;
      if (wr_en === 1'b1) wren_cycles++;
      if (wr_en === 1'b1 && wr_ready === 1'b1) begin
         rec.addr = wr_addr;
         rec.data = wr_data;
         wq.push_back(rec);
      end
   end

   task automatic apply_reset();
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; wr_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int t;
      t = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (in_ready !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) begin
         n_tests++; n_fail++;
         $display("FAIL send_byte_timeout: in_ready stayed %b, required 1", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      send_byte(w[7:0]);
      send_byte(w[15:8]);
      send_byte(w[23:16]);
      send_byte(w[31:24]);
   endtask

   task automatic test_reset();
      rst_n = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; wr_ready = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({in_ready, wr_en, busy, done, err, cpu_hold} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b, required 000000",
                  {in_ready, wr_en, busy, done, err, cpu_hold});
      end
      n_tests++;
      if (word_count !== 13'd0) begin
         n_fail++; $display("FAIL reset_word_count: got %0d, required 0", word_count);
      end
      n_tests++;
      if (wr_addr !== 64'h0 || wr_data !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_wr_bus: got addr %h data %h, required 0/0", wr_addr, wr_data);
      end
      apply_reset();
   endtask

   task automatic test_basic();
      apply_reset();
      wq.delete();
      pulse_start();
      n_tests++;
      if ({busy, cpu_hold, in_ready} !== 3'b111) begin
         n_fail++;
         $display("FAIL basic_start_flags: got %b, required 111", {busy, cpu_hold, in_ready});
      end
      send_word(32'h0000_0002);
      send_word(32'h0010_0513);
      n_tests++;
      if (wr_en !== 1'b1 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_write_latency: got wr_en %b in_ready %b, required 1/0", wr_en, in_ready);
      end
      n_tests++;
      if (wr_addr !== 64'h0 || wr_data !== 32'h0010_0513) begin
         n_fail++;
         $display("FAIL basic_first_word: got %h @ %h, required 00100513 @ 0", wr_data, wr_addr);
      end
      send_word(32'h0020_0593);
      @(negedge clk);
      n_tests++;
      if ({done, busy, cpu_hold, err} !== 4'b1000) begin
         n_fail++;
         $display("FAIL basic_fin_flags: got done/busy/hold/err %b, required 1000",
                  {done, busy, cpu_hold, err});
      end
      n_tests++;
      if (word_count !== 13'd2) begin
         n_fail++; $display("FAIL basic_word_count: got %0d, required 2", word_count);
      end
      n_tests++;
      if (wq.size() != 2) begin
         n_fail++; $display("FAIL basic_write_count: got %0d, required 2", wq.size());
      end else if (wq[0].addr !== 64'h0 || wq[0].data !== 32'h0010_0513 ||
                   wq[1].addr !== 64'h4 || wq[1].data !== 32'h0020_0593) begin
         n_fail++;
         $display("FAIL basic_writes: got %h@%h %h@%h, required 00100513@0 00200593@4",
                  wq[0].data, wq[0].addr, wq[1].data, wq[1].addr);
      end
   endtask

   task automatic test_backpressure();
      apply_reset();
      wq.delete();
      wr_ready = 1'b0;
      pulse_start();
      send_word(32'h0000_0002);
      send_word(32'h0010_0513);
      // next byte already offered but must not be taken during the stall
      in_valid = 1'b1;
      in_data  = 8'h93;
      for (int i = 0; i < 3; i++) begin
         n_tests++;
         if (wr_en !== 1'b1 || wr_addr !== 64'h0 || wr_data !== 32'h0010_0513 ||
             in_ready !== 1'b0 || wq.size() != 0) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: got wr_en %b %h@%h in_ready %b writes %0d, required 1 00100513@0 0 0",
                     i, wr_en, wr_data, wr_addr, in_ready, wq.size());
         end
         @(negedge clk);
      end
      wr_ready = 1'b1;
      @(negedge clk);
      n_tests++;
      if (wq.size() != 1 || word_count !== 13'd1 || wr_en !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_release: got writes %0d count %0d wr_en %b, required 1 1 0",
                  wq.size(), word_count, wr_en);
      end
      send_byte(8'h93);
      send_byte(8'h05);
      send_byte(8'h20);
      send_byte(8'h00);
      @(negedge clk);
      n_tests++;
      if (wq.size() != 2) begin
         n_fail++; $display("FAIL stall_write_count: got %0d, required 2", wq.size());
      end else if (wq[1].addr !== 64'h4 || wq[1].data !== 32'h0020_0593 || done !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_second_word: got %h@%h done %b, required 00200593@4 done 1",
                  wq[1].data, wq[1].addr, done);
      end
   endtask

   task automatic test_full_depth();
      int c0;
      apply_reset();
      wq.delete();
      pulse_start();
      send_word(32'h0000_1000);
      c0 = cyc;
      for (int i = 0; i < 4096; i++) begin
         send_word({16'hC0DE, 16'(i)});
      end
      @(negedge clk);
      n_tests++;
      if (cyc - c0 != 4096 * 5) begin
         n_fail++; $display("FAIL full_throughput: got %0d cycles, required %0d", cyc - c0, 4096 * 5);
      end
      n_tests++;
      if ({done, err, busy} !== 3'b100 || word_count !== 13'h1000) begin
         n_fail++;
         $display("FAIL full_fin: got done/err/busy %b count %0d, required 100 4096",
                  {done, err, busy}, word_count);
      end
      n_tests++;
      if (wq.size() != 4096) begin
         n_fail++; $display("FAIL full_write_count: got %0d, required 4096", wq.size());
      end else if (wq[4095].addr !== 64'h3FFC || wq[4095].data !== 32'hC0DE_0FFF ||
                   wq[0].addr !== 64'h0 || wq[0].data !== 32'hC0DE_0000) begin
         n_fail++;
         $display("FAIL full_last_write: got %h@%h first %h@%h, required C0DE0FFF@3FFC C0DE0000@0",
                  wq[4095].data, wq[4095].addr, wq[0].data, wq[0].addr);
      end
   endtask

   task automatic test_overflow();
      int w0;
      logic [31:0] lens [2];
      lens[0] = 32'h0000_1001;
      lens[1] = 32'h0100_0000;
      for (int k = 0; k < 2; k++) begin
         apply_reset();
         w0 = wren_cycles;
         pulse_start();
         send_word(lens[k]);
         n_tests++;
         if ({err, done, busy, cpu_hold, in_ready} !== 5'b10000) begin
            n_fail++;
            $display("FAIL overflow_flags[%0d]: got err/done/busy/hold/in_ready %b, required 10000",
                     k, {err, done, busy, cpu_hold, in_ready});
         end
         in_valid = 1'b1;
         in_data  = 8'hAA;
         repeat (6) @(negedge clk);
         in_valid = 1'b0;
         n_tests++;
         if (err !== 1'b1 || wren_cycles != w0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_no_write[%0d]: got err %b wr_en cycles %0d in_ready %b, required 1 0 0",
                     k, err, wren_cycles - w0, in_ready);
         end
      end
   endtask

   task automatic test_zero_len();
      int w0;
      apply_reset();
      w0 = wren_cycles;
      pulse_start();
      send_word(32'h0000_0000);
      n_tests++;
      if ({done, err, busy, cpu_hold} !== 4'b1000 || word_count !== 13'd0 || wren_cycles != w0) begin
         n_fail++;
         $display("FAIL zero_len: got done/err/busy/hold %b count %0d writes %0d, required 1000 0 0",
                  {done, err, busy, cpu_hold}, word_count, wren_cycles - w0);
      end
   endtask

   task automatic test_reset_midload();
      apply_reset();
      wq.delete();
      pulse_start();
      send_word(32'h0000_0002);
      send_word(32'h4433_2211);
      send_byte(8'h55);
      send_byte(8'h66);
      in_valid = 1'b1;
      in_data  = 8'h77;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({in_ready, wr_en, busy, done, err, cpu_hold} !== 6'b0 || word_count !== 13'd0 ||
          wr_addr !== 64'h0 || wr_data !== 32'h0) begin
         n_fail++;
         $display("FAIL midload_reset: got flags %b count %0d %h@%h, required 000000 0 0@0",
                  {in_ready, wr_en, busy, done, err, cpu_hold}, word_count, wr_data, wr_addr);
      end
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      wq.delete();
      pulse_start();
      send_word(32'h0000_0001);
      send_word(32'h1234_5678);
      @(negedge clk);
      n_tests++;
      if (wq.size() != 1 || done !== 1'b1) begin
         n_fail++; $display("FAIL midload_reload: got writes %0d done %b, required 1 1", wq.size(), done);
      end else if (wq[0].addr !== 64'h0 || wq[0].data !== 32'h1234_5678) begin
         n_fail++;
         $display("FAIL midload_reload_word: got %h@%h, required 12345678@0", wq[0].data, wq[0].addr);
      end
   endtask

   task automatic test_start_while_busy();
      apply_reset();
      wq.delete();
      pulse_start();
      send_byte(8'h02);
      send_byte(8'h00);
      pulse_start();
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'hEF);
      send_byte(8'hBE);
      pulse_start();
      send_byte(8'hAD);
      send_byte(8'hDE);
      send_word(32'hCAFE_F00D);
      @(negedge clk);
      n_tests++;
      if (wq.size() != 2 || done !== 1'b1 || word_count !== 13'd2) begin
         n_fail++;
         $display("FAIL busy_start_ignored: got writes %0d done %b count %0d, required 2 1 2",
                  wq.size(), done, word_count);
      end else if (wq[0].data !== 32'hDEAD_BEEF || wq[1].data !== 32'hCAFE_F00D ||
                   wq[1].addr !== 64'h4) begin
         n_fail++;
         $display("FAIL busy_start_words: got %h %h@%h, required DEADBEEF CAFEF00D@4",
                  wq[0].data, wq[1].data, wq[1].addr);
      end
      repeat (3) @(negedge clk);
      n_tests++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL done_sticky: got done %b busy %b, required 1 0", done, busy);
      end
      pulse_start();
      n_tests++;
      if ({done, err, busy, cpu_hold} !== 4'b0011 || word_count !== 13'd0) begin
         n_fail++;
         $display("FAIL restart_clears: got done/err/busy/hold %b count %0d, required 0011 0",
                  {done, err, busy, cpu_hold}, word_count);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_zero_len();
      test_overflow();
      test_reset_midload();
      test_start_while_busy();
      test_full_depth();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory. It takes a length-prefixed little-endian byte stream from a UART/debug front end and assembles 32-bit instruction words. It writes each word at consecutive word addresses through the instruction memory's write port and holds the CPU core off while loading. It is the write-side counterpart of the word-addressed instruction store that the fetch stage reads with `im_addr[13:2]`.

## Interface
- `ADDR_W`, 64, width of the byte address driven on `wr_addr`.
- `DEPTH_WORDS`, 4096, capacity of the instruction memory in 32-bit words.
- `BASE_ADDR`, 0, byte address of the first word written; must be 4-byte aligned.
- `clk` in 1: the only clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: single-cycle pulse that begins a load; ignored while `busy`.
- `in_valid` in 1: input byte valid.
- `in_data` in 8: input byte.
- `in_ready` out 1: loader can accept a byte.
- `wr_en` out 1: write request to instruction memory.
- `wr_addr` out ADDR_W: byte address of the word being written.
- `wr_data` out 32: word being written.
- `wr_ready` in 1: memory accepts the write this cycle.
- `busy` out 1: a load is in progress.
- `done` out 1: sticky; last load finished without error.
- `err` out 1: sticky; last load was rejected because its length exceeded `DEPTH_WORDS`.
- `word_count` out 13: number of words written so far in the current load.
- `cpu_hold` out 1: stalls/resets the core while high.

## Operation
- States: IDLE, LEN, DATA, WRITE, FIN, FAIL.
- Stream format:
  - 4 length bytes, little-endian, giving N = the number of words.
  - Then 4·N payload bytes, each word little-endian: byte 0 → `wr_data[7:0]`, byte 3 → `wr_data[31:24]`.
- IDLE:
  - `start` → LEN.
  - Clears `done`, `err`, `word_count`, the byte index and the length register.
  - Sets `busy` and `cpu_hold`.
- LEN:
  - `in_ready`=1; accepts 4 bytes into the length register.
  - On the 4th byte: N=0 → FIN; N>`DEPTH_WORDS` → FAIL; otherwise → DATA.
  - Only the low 32 bits of the length are meaningful; compare at full 32-bit width, with no truncation.
- DATA:
  - `in_ready`=1; shifts bytes into the word buffer.
  - On the 4th byte → WRITE; `in_ready` drops the following cycle.
- WRITE:
  - `wr_en`=1 with `wr_addr` = `BASE_ADDR` + 4·`word_count` and `wr_data` = the buffered word, both held stable until `wr_ready`.
  - In the `wr_ready` cycle: `word_count`++.
  - If `word_count`+1 == N → FIN; else → DATA.
- FIN: `done`=1, `busy`=0, `cpu_hold`=0 → IDLE.
- FAIL: `err`=1, `busy`=0, `cpu_hold`=0 → IDLE. No memory write occurs for a rejected load.
- `start` is ignored unless in IDLE.
- `in_valid` while `in_ready`=0 is not consumed; the source holds its byte.
- `done` and `err` are sticky until the next accepted `start`.

## Timing
- A byte transfers on a rising edge with `in_valid`&&`in_ready`.
- `in_ready` is a registered output; it is never asserted in IDLE, WRITE, FIN or FAIL.
- Latency: the 4th byte of a word accepted at edge k gives `wr_en`=1 in cycle k+1.
- With `wr_ready` tied high, the loader sustains one word per 5 cycles (4 bytes + 1 write).
- `done`/`err` rise one cycle after the final write or length check; `cpu_hold` falls in that same cycle.
- Reset values:
  - State = IDLE.
  - `in_ready`, `wr_en`, `busy`, `done`, `err`, `cpu_hold` = 0.
  - `word_count` = 0; `wr_addr` = `BASE_ADDR`; `wr_data` = 0.
- Reset asserted mid-load:
  - All outputs return to their reset values immediately and asynchronously.
  - A partial word is discarded, and any `wr_en` in progress is dropped.
  - Words already written stay in memory.
- Boundary: N == `DEPTH_WORDS` is legal; the last address written is `BASE_ADDR`+4·(`DEPTH_WORDS`−1).

## Structure
- Shared package `imem_pkg`:
  - `IMEM_DEPTH_WORDS` = 4096.
  - `IMEM_WORD_W` = 32.
  - Load-state enum.
  - Helper: `word_count` width = clog2(`DEPTH_WORDS`+1).
- One natural sub-module, `byte_packer`: 4-byte little-endian assembler with a byte index and a word-complete strobe.
- `imem_loader` itself holds the FSM, the length register, the address/word counter and the write handshake.

## Test plan
- N=2, bytes 02 00 00 00 13 05 10 00 93 05 20 00, `wr_ready`=1:
  - Writes 0x00100513 at `BASE_ADDR`+0, then 0x00200593 at +4.
  - `done`=1, `word_count`=2, `cpu_hold`=0.
- Same stream with `wr_ready` low for 3 cycles on the first write:
  - `wr_en`, `wr_addr` and `wr_data` stay stable, and `in_ready`=0 throughout.
  - The write completes on the `wr_ready` edge.
- Length 00 10 00 00 (4096): final write at address 0x3FFC, then `done`.
- Length 01 10 00 00 (4097): FAIL, `err`=1, no `wr_en` pulse ever.
- Length 0: `done`=1 one cycle after the 4th length byte, with zero writes.
- `rst_n` pulled low after 6 payload bytes:
  - All outputs are at their reset values before the next edge.
  - A new `start` with a full N=1 stream writes correctly at `BASE_ADDR`.
- `start` pulsed again while `busy`: ignored; the current load completes normally.
